// File: rtl/yrv_pkg.sv
// Shared constants for the yrv fetch path: reset PC, length code and the illegal-instruction word.
package yrv_pkg;

  localparam logic [31:0] RST_BASE_DEF = 32'h0000_0000;
  localparam logic [1:0]  LEN32        = 2'b11;
  localparam logic [31:0] ILLEGAL_INST = 32'h0000_0000;

  function automatic logic is_rvc(input logic [15:0] hw);
    return (hw[1:0] != LEN32);
  endfunction

endpackage

// File: rtl/yrv_hw_queue.sv
// Halfword circular FIFO with 0/1/2-entry push and pop per cycle and an occupancy count.
// clr empties the queue in place by moving rd onto wr, and overrides push/pop.
module yrv_hw_queue #(
  parameter int QDEPTH = 4,
  parameter int AW     = $clog2(QDEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic [1:0]    push_n,
  input  logic [15:0]   push_lo,
  input  logic [15:0]   push_hi,
  input  logic [1:0]    pop_n,
  output logic [15:0]   head0,
  output logic [15:0]   head1,
  output logic [AW:0]   count
);

  logic [15:0]   mem_q [QDEPTH];
  logic [15:0]   mem_d [QDEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] wr_nxt_s, rd_nxt_s;

  // next-state for storage, pointers and count
  always_comb begin
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    wr_nxt_s = wr_q + AW'(1'b1);
    if (clr) begin
      rd_d  = wr_q;
      cnt_d = '0;
    end else begin
      if (push_n != 2'd0) begin
        mem_d[wr_q] = push_lo;
      end else begin
        mem_d[wr_q] = mem_q[wr_q];
      end
      if (push_n == 2'd2) begin
        mem_d[wr_nxt_s] = push_hi;
      end else begin
        mem_d[wr_nxt_s] = mem_d[wr_nxt_s];
      end
      wr_d  = wr_q + AW'(push_n);
      rd_d  = rd_q + AW'(pop_n);
      cnt_d = cnt_q + (AW+1)'(push_n) - (AW+1)'(pop_n);
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // head view; the second entry may sit across the wrap point
  always_comb begin
    rd_nxt_s = rd_q + AW'(1'b1);
    head0    = mem_q[rd_q];
    head1    = mem_q[rd_nxt_s];
    count    = cnt_q;
  end

endmodule

// File: rtl/yrv_fetch_align.sv
// Fetch alignment buffer: halfword queue, head PC and instruction length tracking for decode.
// Build option YRV_RVC_EN enables compressed instructions; without it every instruction is 32-bit.
module yrv_fetch_align
  import yrv_pkg::*;
#(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RST_BASE = RST_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_32,
  input  logic        flush,
  input  logic [30:0] flush_pc,
  input  logic        fetch_vld,
  input  logic [31:0] fetch_data,
  output logic        fetch_rdy,
  output logic        inst_vld,
  output logic [31:0] inst_data,
  output logic [30:0] inst_pc,
  output logic        inst_c,
  input  logic        dec_ack,
  output logic        stall_align
);

  localparam int          AW      = $clog2(QDEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(QDEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);

  logic [30:0] pc_q, pc_d;
  logic        mode32_q, mode32_d;
`ifdef YRV_RVC_EN
  logic        drop_q, drop_d;
`else
  logic        mis_q, mis_d;
`endif

  logic [AW:0] count_s;
  logic [15:0] head0_s, head1_s, push_lo_s;
  logic [1:0]  push_n_s, pop_n_s;
  logic        is_c_s, vld_s, push_en_s, pop_en_s;

  yrv_hw_queue #(.QDEPTH(QDEPTH), .AW(AW)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .clr     (flush),
    .push_n  (push_n_s),
    .push_lo (push_lo_s),
    .push_hi (fetch_data[31:16]),
    .pop_n   (pop_n_s),
    .head0   (head0_s),
    .head1   (head1_s),
    .count   (count_s)
  );

  // length decode and handshakes; flush suppresses both push and pop
  always_comb begin
`ifdef YRV_RVC_EN
    is_c_s = is_rvc(head0_s);
`else
    is_c_s = 1'b0;
`endif
    if (is_c_s) begin
      vld_s = (count_s >= ONE_C);
    end else begin
      vld_s = (count_s >= TWO_C);
    end
    fetch_rdy = ((DEPTH_C - count_s) >= TWO_C);
    push_en_s = fetch_vld && fetch_rdy && !flush;
    pop_en_s  = dec_ack && vld_s && !flush;
    if (!pop_en_s) begin
      pop_n_s = 2'd0;
    end else if (is_c_s) begin
      pop_n_s = 2'd1;
    end else begin
      pop_n_s = 2'd2;
    end
  end

  // push shaping: a pending drop skips the stale low half of the first word after a redirect
  always_comb begin
    push_lo_s = fetch_data[15:0];
    if (!push_en_s) begin
      push_n_s = 2'd0;
    end else if (!mode32_q) begin
      push_n_s = 2'd1;
`ifdef YRV_RVC_EN
    end else if (drop_q) begin
      push_n_s  = 2'd1;
      push_lo_s = fetch_data[31:16];
`endif
    end else begin
      push_n_s = 2'd2;
    end
  end

  // head PC, bus mode and redirect alignment state
  always_comb begin
    mode32_d = mode32_q;
    if (flush) begin
      pc_d     = flush_pc;
      mode32_d = bus_32;
    end else if (pop_en_s) begin
      pc_d = pc_q + 31'(pop_n_s);
    end else begin
      pc_d = pc_q;
    end
`ifdef YRV_RVC_EN
    if (flush) begin
      drop_d = flush_pc[0] && bus_32;
    end else if (push_en_s && mode32_q) begin
      drop_d = 1'b0;
    end else begin
      drop_d = drop_q;
    end
`else
    if (flush) begin
      mis_d = flush_pc[0];
    end else if (pop_en_s) begin
      mis_d = 1'b0;
    end else begin
      mis_d = mis_q;
    end
`endif
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RST_BASE[31:1];
      mode32_q <= bus_32;
`ifdef YRV_RVC_EN
      drop_q   <= 1'b0;
`else
      mis_q    <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      mode32_q <= mode32_d;
`ifdef YRV_RVC_EN
      drop_q   <= drop_d;
`else
      mis_q    <= mis_d;
`endif
    end
  end

  // decode-facing outputs, all derived from registered queue and head state
  always_comb begin
    inst_vld    = vld_s;
    inst_c      = vld_s && is_c_s;
    inst_pc     = pc_q;
    stall_align = !vld_s;
    if (!vld_s) begin
      inst_data = 32'h0000_0000;
    end else if (is_c_s) begin
      inst_data = {16'h0000, head0_s};
`ifndef YRV_RVC_EN
    end else if (mis_q) begin
      inst_data = ILLEGAL_INST;
`endif
    end else begin
      inst_data = {head1_s, head0_s};
    end
  end

endmodule

// File: tb/tb_yrv_fetch_align.sv
// Directed self-checking bench for yrv_fetch_align (QDEPTH=4, RST_BASE=0x1000).
module tb_yrv_fetch_align;

  logic        clk = 1'b0;
  logic        reset, bus_32, flush, fetch_vld, dec_ack;
  logic [30:0] flush_pc;
  logic [31:0] fetch_data;
  logic        fetch_rdy, inst_vld, inst_c, stall_align;
  logic [31:0] inst_data;
  logic [30:0] inst_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  yrv_fetch_align #(.QDEPTH(4), .RST_BASE(32'h0000_1000)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_32      (bus_32),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .fetch_vld   (fetch_vld),
    .fetch_data  (fetch_data),
    .fetch_rdy   (fetch_rdy),
    .inst_vld    (inst_vld),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_c      (inst_c),
    .dec_ack     (dec_ack),
    .stall_align (stall_align)
  );

  // upstream must never present data while the buffer has no room
  always @(negedge clk) begin
    if (fetch_vld && !reset) begin
      n_checks++;
      assert (fetch_rdy === 1'b1) else begin
        n_errors++;
        $error("FAIL proto_rdy: observed fetch_rdy=%b expected 1", fetch_rdy);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string tag, input logic v, input logic [31:0] d,
                          input logic [30:0] pc, input logic c);
    chk({tag, ".vld"}, {31'h0, inst_vld}, {31'h0, v});
    chk({tag, ".stall"}, {31'h0, stall_align}, {31'h0, !v});
    chk({tag, ".pc"}, {1'b0, inst_pc}, {1'b0, pc});
    if (v) begin
      chk({tag, ".data"}, inst_data, d);
      chk({tag, ".c"}, {31'h0, inst_c}, {31'h0, c});
    end
  endtask

  task automatic chk_rdy(input string tag, input logic r);
    chk({tag, ".rdy"}, {31'h0, fetch_rdy}, {31'h0, r});
  endtask

  task automatic push(input logic [31:0] d);
    fetch_vld  = 1'b1;
    fetch_data = d;
    cyc();
    fetch_vld  = 1'b0;
    fetch_data = 32'h0000_0000;
  endtask

  task automatic pop();
    dec_ack = 1'b1;
    cyc();
    dec_ack = 1'b0;
  endtask

  task automatic do_flush(input logic [30:0] p);
    flush    = 1'b1;
    flush_pc = p;
    cyc();
    flush    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bus_32 = 1'b1; flush = 1'b0; flush_pc = 31'h0;
    fetch_vld = 1'b0; fetch_data = 32'h0; dec_ack = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk_inst("rst", 1'b0, 32'h0, 31'h800, 1'b0);
    chk("rst.data", inst_data, 32'h0000_0000);
    chk("rst.c", {31'h0, inst_c}, 32'h0);
    chk_rdy("rst", 1'b1);

    // single 32-bit instruction in 32-bit mode
    push(32'h0001_0113);
    chk_inst("w32", 1'b1, 32'h0001_0113, 31'h800, 1'b0);
    chk_rdy("w32", 1'b1);
    pop();
    chk_inst("w32_pop", 1'b0, 32'h0, 31'h802, 1'b0);
    pop();
    chk_inst("ack_empty", 1'b0, 32'h0, 31'h802, 1'b0);

    // fill to QDEPTH, then simultaneous push and pop
    push(32'h00A0_0093);
    push(32'h0010_0113);
    chk_inst("full", 1'b1, 32'h00A0_0093, 31'h802, 1'b0);
    chk_rdy("full", 1'b0);
    pop();
    chk_inst("full_pop", 1'b1, 32'h0010_0113, 31'h804, 1'b0);
    chk_rdy("full_pop", 1'b1);
    fetch_vld = 1'b1; fetch_data = 32'h0020_0193; dec_ack = 1'b1;
    cyc();
    fetch_vld = 1'b0; dec_ack = 1'b0;
    chk_inst("pushpop", 1'b1, 32'h0020_0193, 31'h806, 1'b0);
    chk_rdy("pushpop", 1'b1);
    pop();
    chk_inst("drain", 1'b0, 32'h0, 31'h808, 1'b0);

    // flush beats push and pop in the same cycle
    push(32'h0030_0213);
    flush = 1'b1; flush_pc = 31'h200; fetch_vld = 1'b1; fetch_data = 32'hDEAD_BEEF; dec_ack = 1'b1;
    cyc();
    flush = 1'b0; fetch_vld = 1'b0; dec_ack = 1'b0;
    chk_inst("flush_all", 1'b0, 32'h0, 31'h200, 1'b0);
    chk_rdy("flush_all", 1'b1);
    push(32'h0040_0293);
    chk_inst("after_flush", 1'b1, 32'h0040_0293, 31'h200, 1'b0);
    pop();

`ifdef YRV_RVC_EN
    push(32'h4501_4505);
    chk_inst("rvc0", 1'b1, 32'h0000_4505, 31'h202, 1'b1);
    pop();
    chk_inst("rvc1", 1'b1, 32'h0000_4501, 31'h203, 1'b1);
    pop();
    chk_inst("rvc_empty", 1'b0, 32'h0, 31'h204, 1'b0);
    do_flush(31'h41);
    push(32'h0013_4505);
    chk_inst("drop", 1'b0, 32'h0, 31'h41, 1'b0);
    push(32'h0000_0001);
    chk_inst("drop_asm", 1'b1, 32'h0001_0013, 31'h41, 1'b0);
    chk_rdy("drop_asm", 1'b0);
    pop();
    chk_inst("drop_tail", 1'b1, 32'h0000_0000, 31'h43, 1'b1);
    pop();
    chk_inst("drop_empty", 1'b0, 32'h0, 31'h44, 1'b0);
`else
    do_flush(31'h41);
    chk_inst("mis_flush", 1'b0, 32'h0, 31'h41, 1'b0);
    push(32'h0001_0113);
    chk_inst("mis_illegal", 1'b1, 32'h0000_0000, 31'h41, 1'b0);
    pop();
    chk_inst("mis_pop", 1'b0, 32'h0, 31'h43, 1'b0);
    push(32'h0001_0113);
    chk_inst("mis_clear", 1'b1, 32'h0001_0113, 31'h43, 1'b0);
    pop();
`endif

    // 16-bit bus: fill to count 3 and assemble an instruction across the wrap
    reset = 1'b1; bus_32 = 1'b0;
    cyc();
    reset = 1'b0;
    chk_inst("rst16", 1'b0, 32'h0, 31'h800, 1'b0);
    push(32'hFFFF_1111);
    do_flush(31'h100);
    chk_inst("f16", 1'b0, 32'h0, 31'h100, 1'b0);
    chk_rdy("f16", 1'b1);
    push(32'h5555_0113);
    push(32'h0000_0001);
    push(32'h0000_0293);
    chk_inst("h3", 1'b1, 32'h0001_0113, 31'h100, 1'b0);
    chk_rdy("h3", 1'b0);
    pop();
    chk_inst("h1", 1'b0, 32'h0, 31'h102, 1'b0);
    chk_rdy("h1", 1'b1);
    push(32'h0000_0002);
    chk_inst("wrap", 1'b1, 32'h0002_0293, 31'h102, 1'b0);
    pop();
    chk_inst("wrap_pop", 1'b0, 32'h0, 31'h104, 1'b0);

    // reset mid-stream wins over flush, push and pop
    push(32'h0001_0113);
    push(32'h0000_0001);
    chk_inst("pre_rst", 1'b1, 32'h0001_0113, 31'h104, 1'b0);
    bus_32 = 1'b1; reset = 1'b1; flush = 1'b1; flush_pc = 31'h7;
    fetch_vld = 1'b1; fetch_data = 32'h1234_5673; dec_ack = 1'b1;
    cyc();
    reset = 1'b0; flush = 1'b0; fetch_vld = 1'b0; dec_ack = 1'b0;
    chk_inst("mid_rst", 1'b0, 32'h0, 31'h800, 1'b0);
    chk("mid_rst.data", inst_data, 32'h0000_0000);
    chk("mid_rst.c", {31'h0, inst_c}, 32'h0);
    chk_rdy("mid_rst", 1'b1);
    push(32'h0001_0113);
    chk_inst("post_rst", 1'b1, 32'h0001_0113, 31'h800, 1'b0);
    push(32'h0002_0293);
    chk_rdy("post_rst_mode", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
